adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable SPI-slave model of the front-end pair driven by the ADC capture block: LTC6912 programmable preamp (AMP_CS/SPI_MOSI/AMP_DOUT) and LTC1407A dual ADC (AD_CONV/AD_DOUT).
- Sits opposite the ADC master, either in loopback builds or in benches.
- Returns user-supplied 14-bit samples in the exact frame the master expects.
- Decodes gain writes and exposes them to the fabric.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on SPI_SCK, SPI_MOSI, AMP_CS, AD_CONV.
- DATA_W, 14, sample width per channel.
- GAP_BITS, 2, zero bits before channel A, between A and B, and after B.

Ports:
- clk  in  1  system clock; oversamples all SPI pins.
- rst  in  1  asynchronous, active-low reset.
- SPI_SCK  in  1  serial clock from master.
- SPI_MOSI  in  1  amp command data from master.
- AMP_CS  in  1  amp chip select, active low.
- AD_CONV  in  1  conversion strobe; rising edge starts a frame.
- AD_DOUT  out  1  ADC serial data to master.
- AMP_DOUT  out  1  amp readback data (previous gain byte).
- sample_a  in  DATA_W  channel A value, two's complement.
- sample_b  in  DATA_W  channel B value, two's complement.
- sample_ack  out  1  1-cycle pulse when sample_a/b are latched.
- gain_a  out  4  current channel A gain code.
- gain_b  out  4  current channel B gain code.
- gain_valid  out  1  1-cycle pulse when gain_a/b update.
- gain_err  out  1  1-cycle pulse when a CS window ends with a bit count other than 8.

Behaviour:
- Reset (rst=0, async)
  - All outputs 0.
  - Both FSMs idle.
  - Synchronizers cleared.
  - Gain register 8'h00.
- Input conditioning and edge timing
  - Every input passes through SYNC_STAGES flops.
  - Edges are detected against a further registered copy.
  - Outputs change SYNC_STAGES+1 clk cycles after the pin edge.
  - The master must hold SCK high and low for at least SYNC_STAGES+2 clk each; behaviour is unspecified otherwise.
- ADC FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on an AD_CONV rising edge:
    - latch sample_a/sample_b;
    - pulse sample_ack;
    - bit counter = 0;
    - AD_DOUT = 0.
  - Frame length is FRAME = 3*GAP_BITS + 2*DATA_W (34 at defaults).
  - Bit index after each counted SCK falling edge:
    - [0, GAP_BITS): 0
    - next DATA_W bits: A, MSB first
    - next GAP_BITS: 0
    - next DATA_W bits: B, MSB first
    - last GAP_BITS: 0
  - AD_DOUT presents bit k after the (k+1)-th falling edge.
  - SHIFT -> IDLE after the FRAME-th falling edge. AD_DOUT holds 0 in IDLE.
  - SCK falling edges while AMP_CS=0 are not counted.
  - AD_CONV rising during SHIFT aborts the frame and restarts as from IDLE (new latch, new sample_ack).
- AMP FSM states: AMP_IDLE, AMP_SHIFT.
  - AMP_CS falling edge -> AMP_SHIFT:
    - shift-out register = current gain byte;
    - AMP_DOUT = its MSB;
    - bit count = 0.
  - In AMP_SHIFT:
    - SPI_MOSI sampled on each SCK rising edge into an 8-bit shift-in register, MSB first; count saturates at 15.
    - AMP_DOUT shifts to the next bit on each SCK falling edge.
  - AMP_CS rising edge:
    - count==8: gain_b = byte[7:4], gain_a = byte[3:0], gain_valid pulse.
    - otherwise: gains unchanged, gain_err pulse.
    - Then AMP_IDLE, AMP_DOUT=0.
- Reset asserted mid-frame or mid-command drops everything to reset values immediately. No partial gain update.

Decomposition:
- Shared package for the front-end model:
  - FRAME length function;
  - gain-field positions (B = [7:4], A = [3:0]);
  - ADC and AMP state typedefs.
- One sub-module, spi_pin_sync:
  - parameterised SYNC_STAGES synchronizer plus rise/fall edge detector;
  - instantiated once per SPI input.

Test Plan:
- ADC frame:
  - Stimulus: reset; sample_a=14'h1ABC, sample_b=14'h2555; CONV pulse; 34 SCK periods of 8 clk.
  - Required: master-captured bits = 00, 1ABC MSB-first, 00, 2555 MSB-first, 00; sample_ack exactly once; AD_DOUT=0 afterwards.
- Gain write:
  - Stimulus: AMP_CS low, 8 SCKs carrying 8'h11, CS high.
  - Required: gain_a=1, gain_b=1, one gain_valid; AMP_DOUT during the transfer = 00000000.
- Readback:
  - Stimulus: second write of 8'h34.
  - Required: AMP_DOUT shifts 8'h11 MSB-first; afterwards gain_b=3, gain_a=4.
- Bad count:
  - Stimulus: CS window with 7 SCKs, then one with 9 SCKs.
  - Required: gain_err pulses twice; gains stay 3/4; no gain_valid.
- Abort:
  - Stimulus: CONV re-asserted after 10 bits with sample_a changed to 14'h0001.
  - Required: new frame restarts at bit 0 and returns 0001; sample_ack pulses twice in total.
- Async reset:
  - Stimulus: rst low mid-frame (bit 20) and mid-command (bit 4).
  - Required: all outputs 0 within the same cycle; gains 0; the next frame is correct.

Source files
------------

// File: rtl/adc_spi_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : adc_spi_responder_pkg
// Desc   : Shared constants, state types and frame helper for the ADC/amp model
// Rev    : 1.0
// ============================================================================
package adc_spi_responder_pkg;

  localparam int c_amp_bits   = 8;
  localparam int c_amp_cnt_w  = 4;
  localparam int c_gain_b_msb = 7;
  localparam int c_gain_b_lsb = 4;
  localparam int c_gain_a_msb = 3;
  localparam int c_gain_a_lsb = 0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } adc_state_t;

  typedef enum logic [0:0] {
    AMP_IDLE  = 1'b0,
    AMP_SHIFT = 1'b1
  } amp_state_t;

  // Leading gap, A, middle gap, B, trailing gap.
  function automatic int frame_len(input int gap_bits, input int data_w);
    return 3 * gap_bits + 2 * data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_responder_spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module : spi_pin_sync
// Desc   : SYNC_STAGES-deep synchronizer with rise/fall detection on one pin
// Rev    : 1.0
// ============================================================================
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= pin;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 1'b0;
    else      r_prev <= level;
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module : adc_spi_responder
// Desc   : SPI-slave model of the LTC6912 preamp and LTC1407A dual ADC
// Rev    : 1.0
// ============================================================================
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 14,
  parameter int GAP_BITS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPI_SCK,
  input  logic              SPI_MOSI,
  input  logic              AMP_CS,
  input  logic              AD_CONV,
  output logic              AD_DOUT,
  output logic              AMP_DOUT,
  input  logic [DATA_W-1:0] sample_a,
  input  logic [DATA_W-1:0] sample_b,
  output logic              sample_ack,
  output logic [3:0]        gain_a,
  output logic [3:0]        gain_b,
  output logic              gain_valid,
  output logic              gain_err
);

  localparam int c_frame = frame_len(GAP_BITS, DATA_W);
  localparam int c_cnt_w = $clog2(c_frame + 1);
  localparam logic [c_cnt_w-1:0]     c_last_bit = c_cnt_w'(c_frame - 1);
  localparam logic [c_amp_cnt_w-1:0] c_amp_full = c_amp_cnt_w'(c_amp_bits);
  localparam logic [c_amp_cnt_w-1:0] c_amp_sat  = '1;

  localparam int c_pin_sck  = 0;
  localparam int c_pin_mosi = 1;
  localparam int c_pin_cs   = 2;
  localparam int c_pin_conv = 3;

  logic [3:0] w_pin;
  logic [3:0] w_lvl;
  logic [3:0] w_rise;
  logic [3:0] w_fall;

  assign w_pin = {AD_CONV, AMP_CS, SPI_MOSI, SPI_SCK};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sync
      spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (w_pin[i]),
        .level(w_lvl[i]),
        .rise (w_rise[i]),
        .fall (w_fall[i])
      );
    end
  endgenerate

  logic w_sck_rise, w_sck_fall, w_mosi, w_cs_high, w_cs_rise, w_cs_fall, w_conv_rise;
  assign w_sck_rise  = w_rise[c_pin_sck];
  assign w_sck_fall  = w_fall[c_pin_sck];
  assign w_mosi      = w_lvl[c_pin_mosi];
  assign w_cs_high   = w_lvl[c_pin_cs];
  assign w_cs_rise   = w_rise[c_pin_cs];
  assign w_cs_fall   = w_fall[c_pin_cs];
  assign w_conv_rise = w_rise[c_pin_conv];

  logic w_unused;
  assign w_unused = ^{w_lvl[c_pin_sck], w_rise[c_pin_mosi], w_fall[c_pin_mosi],
                      w_lvl[c_pin_conv], w_fall[c_pin_conv]};

  // ADC side: the whole frame, gaps included, is loaded into one shift register.
  adc_state_t           r_adc_state;
  logic [c_frame-1:0]   r_adc_sh;
  logic [c_cnt_w-1:0]   r_bit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adc_state <= IDLE;
      r_adc_sh    <= '0;
      r_bit_cnt   <= '0;
      AD_DOUT     <= 1'b0;
      sample_ack  <= 1'b0;
    end else begin
      sample_ack <= 1'b0;
      if (w_conv_rise) begin
        r_adc_state <= SHIFT;
        r_adc_sh    <= {{GAP_BITS{1'b0}}, sample_a, {GAP_BITS{1'b0}}, sample_b,
                        {GAP_BITS{1'b0}}};
        r_bit_cnt   <= '0;
        AD_DOUT     <= 1'b0;
        sample_ack  <= 1'b1;
      end else if (r_adc_state == SHIFT && w_sck_fall && w_cs_high) begin
        AD_DOUT  <= r_adc_sh[c_frame-1];
        r_adc_sh <= {r_adc_sh[c_frame-2:0], 1'b0};
        if (r_bit_cnt == c_last_bit) begin
          r_adc_state <= IDLE;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  amp_state_t                r_amp_state;
  logic [c_amp_bits-1:0]     r_gain;
  logic [c_amp_bits-1:0]     r_amp_in;
  logic [c_amp_bits-1:0]     r_amp_out;
  logic [c_amp_cnt_w-1:0]    r_amp_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_amp_state <= AMP_IDLE;
      r_gain      <= '0;
      r_amp_in    <= '0;
      r_amp_out   <= '0;
      r_amp_cnt   <= '0;
      AMP_DOUT    <= 1'b0;
      gain_valid  <= 1'b0;
      gain_err    <= 1'b0;
    end else begin
      gain_valid <= 1'b0;
      gain_err   <= 1'b0;
      case (r_amp_state)
        AMP_IDLE: begin
          if (w_cs_fall) begin
            r_amp_state <= AMP_SHIFT;
            r_amp_out   <= r_gain;
            AMP_DOUT    <= r_gain[c_amp_bits-1];
            r_amp_cnt   <= '0;
          end
        end
        AMP_SHIFT: begin
          if (w_cs_rise) begin
            if (r_amp_cnt == c_amp_full) begin
              r_gain     <= r_amp_in;
              gain_valid <= 1'b1;
            end else begin
              gain_err <= 1'b1;
            end
            r_amp_state <= AMP_IDLE;
            AMP_DOUT    <= 1'b0;
          end else begin
            if (w_sck_rise) begin
              r_amp_in <= {r_amp_in[c_amp_bits-2:0], w_mosi};
              if (r_amp_cnt != c_amp_sat) r_amp_cnt <= r_amp_cnt + 1'b1;
            end
            if (w_sck_fall) begin
              r_amp_out <= {r_amp_out[c_amp_bits-2:0], 1'b0};
              AMP_DOUT  <= r_amp_out[c_amp_bits-2];
            end
          end
        end
        default: r_amp_state <= AMP_IDLE;
      endcase
    end
  end

  assign gain_b = r_gain[c_gain_b_msb:c_gain_b_lsb];
  assign gain_a = r_gain[c_gain_a_msb:c_gain_a_lsb];

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_spi_responder
// Desc   : Directed self-checking bench for adc_spi_responder
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_adc_spi_responder;

  localparam int DW = 14;
  localparam int GB = 2;
  localparam int FR = 3 * GB + 2 * DW;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          SPI_SCK  = 1'b1;
  logic          SPI_MOSI = 1'b0;
  logic          AMP_CS   = 1'b1;
  logic          AD_CONV  = 1'b0;
  logic [DW-1:0] sample_a = '0;
  logic [DW-1:0] sample_b = '0;
  logic          AD_DOUT, AMP_DOUT, sample_ack, gain_valid, gain_err;
  logic [3:0]    gain_a, gain_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [7:0] m_gain       = 8'h00;
  bit         chk_gain     = 1'b0;
  bit         chk_adc_idle = 1'b0;
  bit         chk_amp_idle = 1'b0;

  always #5 clk = ~clk;

  adc_spi_responder #(
    .SYNC_STAGES(2),
    .DATA_W     (DW),
    .GAP_BITS   (GB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SPI_SCK   (SPI_SCK),
    .SPI_MOSI  (SPI_MOSI),
    .AMP_CS    (AMP_CS),
    .AD_CONV   (AD_CONV),
    .AD_DOUT   (AD_DOUT),
    .AMP_DOUT  (AMP_DOUT),
    .sample_a  (sample_a),
    .sample_b  (sample_b),
    .sample_ack(sample_ack),
    .gain_a    (gain_a),
    .gain_b    (gain_b),
    .gain_valid(gain_valid),
    .gain_err  (gain_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: bit k of a frame, from the gap/A/gap/B/gap layout.
  function automatic logic adc_bit(input logic [DW-1:0] a, input logic [DW-1:0] b, input int k);
    if (k < GB)               return 1'b0;
    else if (k < GB + DW)     return a[DW-1-(k-GB)];
    else if (k < 2*GB + DW)   return 1'b0;
    else if (k < 2*GB + 2*DW) return b[DW-1-(k-2*GB-DW)];
    else                      return 1'b0;
  endfunction

  function automatic logic [FR-1:0] exp_frame(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [FR-1:0] f;
    f = '0;
    for (int k = 0; k < FR; k++) f[FR-1-k] = adc_bit(a, b, k);
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (sample_ack === 1'b1) n_ack++;
      if (gain_valid === 1'b1) n_valid++;
      if (gain_err === 1'b1)   n_err++;
      if (chk_gain) begin
        check("gain_a", {60'd0, gain_a}, {60'd0, m_gain[3:0]});
        check("gain_b", {60'd0, gain_b}, {60'd0, m_gain[7:4]});
      end
      if (chk_adc_idle) check("ad_dout_idle", {63'd0, AD_DOUT}, 64'd0);
      if (chk_amp_idle) check("amp_dout_idle", {63'd0, AMP_DOUT}, 64'd0);
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic adc_start(input logic [DW-1:0] a, input logic [DW-1:0] b);
    chk_adc_idle = 1'b0;
    sample_a = a;
    sample_b = b;
    AD_CONV = 1'b1;
    wclk(4);
    AD_CONV = 1'b0;
    wclk(4);
    check("ad_dout_after_conv", {63'd0, AD_DOUT}, 64'd0);
  endtask

  task automatic adc_bits(input int n, output logic [FR-1:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      SPI_SCK = 1'b0;
      wclk(4);
      SPI_SCK = 1'b1;
      wclk(4);
      cap = {cap[FR-2:0], AD_DOUT};
    end
  endtask

  task automatic amp_xfer(input logic [7:0] cmd, input int nbits, output logic [7:0] rb);
    chk_amp_idle = 1'b0;
    rb = '0;
    AMP_CS = 1'b0;
    wclk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) rb[7-i] = AMP_DOUT;
      SPI_MOSI = (i < 8) ? cmd[7-i] : 1'b0;
      SPI_SCK  = 1'b0;
      wclk(4);
      SPI_SCK  = 1'b1;
      wclk(4);
    end
    chk_gain = 1'b0;
    AMP_CS = 1'b1;
    wclk(6);
    SPI_MOSI = 1'b0;
    if (nbits == 8) m_gain = cmd;
    chk_gain = 1'b1;
    check("amp_dout_after_cs", {63'd0, AMP_DOUT}, 64'd0);
    chk_amp_idle = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FR-1:0] cap;
    logic [7:0]    rb;
    logic [7:0]    prev;
    int            a0, v0, e0;

    wclk(3);
    check("reset_outputs",
          {50'd0, AD_DOUT, AMP_DOUT, sample_ack, gain_a, gain_b, gain_valid, gain_err}, 64'd0);
    rst = 1'b1;
    wclk(4);
    chk_gain = 1'b1; chk_adc_idle = 1'b1; chk_amp_idle = 1'b1;

    // Full ADC frame.
    a0 = n_ack;
    adc_start(14'h1ABC, 14'h2555);
    adc_bits(FR, cap);
    check("frame1_model", {30'd0, cap}, {30'd0, exp_frame(14'h1ABC, 14'h2555)});
    check("frame1_literal", {30'd0, cap}, 64'h0_6AF0_9554);
    wclk(4);
    check("frame1_ack_count", n_ack - a0, 1);
    chk_adc_idle = 1'b1;

    // First gain write reads back the reset gain.
    v0 = n_valid; prev = m_gain;
    amp_xfer(8'h11, 8, rb);
    check("wr1_readback", {56'd0, rb}, {56'd0, prev});
    check("wr1_readback_lit", {56'd0, rb}, 64'h00);
    check("wr1_gains_lit", {56'd0, gain_b, gain_a}, 64'h11);
    check("wr1_valid_count", n_valid - v0, 1);

    // Second write reads back the first.
    prev = m_gain;
    amp_xfer(8'h34, 8, rb);
    check("wr2_readback", {56'd0, rb}, {56'd0, prev});
    check("wr2_readback_lit", {56'd0, rb}, 64'h11);
    check("wr2_gains_lit", {56'd0, gain_b, gain_a}, 64'h34);

    // Wrong bit counts.
    v0 = n_valid; e0 = n_err;
    amp_xfer(8'hAB, 7, rb);
    amp_xfer(8'hCD, 9, rb);
    check("bad_err_count", n_err - e0, 2);
    check("bad_valid_count", n_valid - v0, 0);
    check("bad_gains_lit", {56'd0, gain_b, gain_a}, 64'h34);

    // Abort after 10 bits and restart with a new sample.
    a0 = n_ack;
    adc_start(14'h1ABC, 14'h2555);
    adc_bits(10, cap);
    adc_start(14'h0001, 14'h2555);
    adc_bits(FR, cap);
    check("abort_model", {30'd0, cap}, {30'd0, exp_frame(14'h0001, 14'h2555)});
    check("abort_literal", {30'd0, cap}, 64'h0_0004_9554);
    wclk(4);
    check("abort_ack_count", n_ack - a0, 2);
    chk_adc_idle = 1'b1;

    // Reset mid-frame at bit 20.
    adc_start(14'h0000, 14'h3FFF);
    adc_bits(20, cap);
    check("pre_reset_ad_dout", {63'd0, AD_DOUT}, {63'd0, adc_bit(14'h0000, 14'h3FFF, 19)});
    chk_gain = 1'b0;
    #2 rst = 1'b0;
    #1 check("reset_mid_frame",
             {50'd0, AD_DOUT, AMP_DOUT, sample_ack, gain_a, gain_b, gain_valid, gain_err}, 64'd0);
    m_gain = 8'h00;
    SPI_SCK = 1'b1;
    wclk(2);
    rst = 1'b1;
    wclk(4);
    chk_gain = 1'b1; chk_adc_idle = 1'b1;

    // Reset mid-command.
    amp_xfer(8'h34, 8, rb);
    v0 = n_valid;
    chk_amp_idle = 1'b0;
    AMP_CS = 1'b0;
    wclk(4);
    for (int i = 0; i < 5; i++) begin
      SPI_MOSI = 1'b1;
      SPI_SCK = 1'b0;
      wclk(4);
      SPI_SCK = 1'b1;
      wclk(4);
    end
    check("pre_reset_amp_dout", {63'd0, AMP_DOUT}, 64'd1);
    chk_gain = 1'b0;
    #2 rst = 1'b0;
    #1 check("reset_mid_cmd",
             {50'd0, AD_DOUT, AMP_DOUT, sample_ack, gain_a, gain_b, gain_valid, gain_err}, 64'd0);
    m_gain = 8'h00;
    AMP_CS = 1'b1; SPI_SCK = 1'b1; SPI_MOSI = 1'b0;
    wclk(2);
    rst = 1'b1;
    wclk(4);
    chk_gain = 1'b1; chk_amp_idle = 1'b1;
    check("reset_no_valid", n_valid - v0, 0);

    // Post-reset frame and write.
    adc_start(14'h1ABC, 14'h2555);
    adc_bits(FR, cap);
    check("post_reset_frame", {30'd0, cap}, 64'h0_6AF0_9554);
    wclk(4);
    chk_adc_idle = 1'b1;
    amp_xfer(8'h5A, 8, rb);
    check("post_reset_readback", {56'd0, rb}, 64'h00);
    check("post_reset_gains", {56'd0, gain_b, gain_a}, 64'h5A);

    wclk(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
